// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage:
// funct3 access modes, FSM states, AXI response codes.
package mem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  // AXI size code: byte=0, half=1, word=2
  function automatic logic [2:0] size_of(input logic [2:0] mode);
    return mode[1] ? 3'd2 : {2'b00, mode[0]};
  endfunction

  function automatic logic misaligned(
    input logic [2:0] mode,
    input logic [1:0] lo
  );
    logic [2:0] sz;
    sz = size_of(mode);
    return (sz == 3'd1 && lo[0]) || (sz == 3'd2 && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobe/replication and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_val
);

  logic [15:0] sh;

  // lane selection and extension, purely combinational
  always_comb begin
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    sh        = 16'(rdata >> {addr_lo, 3'b000});
    load_val  = rdata;
    case (size_of(mode))
      3'd0: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      3'd1: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    case (mode)
      MODE_B:  load_val = {{24{sh[7]}}, sh[7:0]};
      MODE_H:  load_val = {{16{sh[15]}}, sh};
      MODE_BU: load_val = {24'h0, sh[7:0]};
      MODE_HU: load_val = {16'h0, sh};
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_axi.sv
// M-stage load/store unit: single-beat AXI4 master with
// pipeline stall, misalignment detection and bus timeout.
module mem_stage_axi
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic              fp_store_m,
  input  logic [ADDR_W-1:0] alu_rsl_m,
  input  logic [31:0]       wdata_m,
  input  logic [31:0]       wdata_f_m,
  input  logic [2:0]        mode_m,
  output logic              stall_m,
  output logic [31:0]       load_data_m,
  output logic              done_m,
  output logic              misalign_err,
  output logic              bus_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awsize,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lo_q;
  logic [2:0]       mode_q;
  logic             aw_done;
  logic             w_done;

  logic        req;
  logic        idle;
  logic        aw_ok;
  logic        w_ok;
  logic        timeout;
  logic [2:0]  sel_mode;
  logic [1:0]  sel_lo;
  logic [31:0] st_data;
  logic [3:0]  strb;
  logic [31:0] rep;
  logic [31:0] ext;
  logic        unused;

  assign req      = mem_read_m | mem_write_m;
  assign stall_m  = req & ~done_m;
  assign idle     = (state == S_IDLE);
  assign sel_mode = idle ? mode_m : mode_q;
  assign sel_lo   = idle ? alu_rsl_m[1:0] : lo_q;
  assign st_data  = fp_store_m ? wdata_f_m : wdata_m;
  assign aw_ok    = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_ok     = w_done | (m_axi_wvalid & m_axi_wready);
  assign timeout  = (cnt == CNT_MAX);
  assign m_axi_wlast = 1'b1;
  assign unused   = m_axi_rlast;

  mem_lane_align u_align (
    .mode      (sel_mode),
    .addr_lo   (sel_lo),
    .wdata     (st_data),
    .rdata     (m_axi_rdata),
    .wstrb     (strb),
    .wdata_rep (rep),
    .load_val  (ext)
  );

  // transaction FSM with registered AXI and completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lo_q          <= '0;
      mode_q        <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      load_data_m   <= '0;
      done_m        <= 1'b0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awsize  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arsize  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      done_m       <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= cnt + 1'b1;
      if (!idle && state != S_DONE && timeout) begin
        state         <= S_DONE;
        cnt           <= '0;
        done_m        <= 1'b1;
        bus_err       <= 1'b1;
        load_data_m   <= '0;
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            cnt    <= '0;
            lo_q   <= alu_rsl_m[1:0];
            mode_q <= mode_m;
            if (req && misaligned(mode_m, alu_rsl_m[1:0])) begin
              state        <= S_DONE;
              done_m       <= 1'b1;
              misalign_err <= 1'b1;
              load_data_m  <= '0;
            end else if (mem_write_m) begin
              state         <= S_WR;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              m_axi_awaddr  <= {alu_rsl_m[ADDR_W-1:2], 2'b00};
              m_axi_awsize  <= size_of(mode_m);
              m_axi_awvalid <= 1'b1;
              m_axi_wdata   <= rep;
              m_axi_wstrb   <= strb;
              m_axi_wvalid  <= 1'b1;
            end else if (mem_read_m) begin
              state         <= S_RD_ADDR;
              m_axi_araddr  <= alu_rsl_m;
              m_axi_arsize  <= size_of(mode_m);
              m_axi_arvalid <= 1'b1;
            end
          end
          S_WR: begin
            if (m_axi_awvalid && m_axi_awready) begin
              m_axi_awvalid <= 1'b0;
              aw_done       <= 1'b1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
              m_axi_wvalid <= 1'b0;
              w_done       <= 1'b1;
            end
            if (aw_ok && w_ok) begin
              state        <= S_WR_RESP;
              cnt          <= '0;
              m_axi_bready <= 1'b1;
            end
          end
          S_WR_RESP: begin
            if (m_axi_bvalid) begin
              state        <= S_DONE;
              cnt          <= '0;
              m_axi_bready <= 1'b0;
              done_m       <= 1'b1;
              bus_err      <= (m_axi_bresp != RESP_OKAY);
              load_data_m  <= '0;
            end
          end
          S_RD_ADDR: begin
            if (m_axi_arready) begin
              state         <= S_RD_DATA;
              cnt           <= '0;
              m_axi_arvalid <= 1'b0;
              m_axi_rready  <= 1'b1;
            end
          end
          S_RD_DATA: begin
            if (m_axi_rvalid) begin
              state        <= S_DONE;
              cnt          <= '0;
              m_axi_rready <= 1'b0;
              done_m       <= 1'b1;
              bus_err      <= (m_axi_rresp != RESP_OKAY);
              load_data_m  <= ext;
            end
          end
          S_DONE: begin
            state       <= S_IDLE;
            cnt         <= '0;
            load_data_m <= '0;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_axi.sv
// Directed bench for mem_stage_axi with a configurable
// zero/multi-wait AXI slave model driven on the falling edge.
module tb_mem_stage_axi;
  import mem_pkg::*;

  localparam int AW = 32;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read_m = 0, mem_write_m = 0, fp_store_m = 0;
  logic [AW-1:0] alu_rsl_m = '0;
  logic [31:0]   wdata_m = '0, wdata_f_m = '0;
  logic [2:0]    mode_m = '0;
  logic          stall_m, done_m, misalign_err, bus_err;
  logic [31:0]   load_data_m;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awsize, m_axi_arsize;
  logic          m_axi_awvalid, m_axi_wvalid, m_axi_wlast;
  logic          m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_awready = 0, m_axi_wready = 0;
  logic          m_axi_bvalid = 0, m_axi_arready = 0;
  logic          m_axi_rvalid = 0, m_axi_rlast = 0;
  logic [1:0]    m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0]   m_axi_rdata = '0;

  always #5 clk = ~clk;

  mem_stage_axi #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .fp_store_m(fp_store_m), .alu_rsl_m(alu_rsl_m),
    .wdata_m(wdata_m), .wdata_f_m(wdata_f_m), .mode_m(mode_m),
    .stall_m(stall_m), .load_data_m(load_data_m),
    .done_m(done_m), .misalign_err(misalign_err),
    .bus_err(bus_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave configuration and capture
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  bit silent = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = '0;
  bit seen_aw = 0, seen_ar = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awsize, cap_arsize;

  // slave: readies/valids updated on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    end else begin
      if (m_axi_awvalid) begin
        seen_aw = 1;
        cap_awaddr = m_axi_awaddr;
        cap_awsize = m_axi_awsize;
        m_axi_awready = !silent && aw_c >= aw_dly;
        aw_c++;
      end else begin
        m_axi_awready = 0; aw_c = 0;
      end
      if (m_axi_wvalid) begin
        cap_wdata = m_axi_wdata;
        cap_wstrb = m_axi_wstrb;
        m_axi_wready = !silent && w_c >= w_dly;
        w_c++;
      end else begin
        m_axi_wready = 0; w_c = 0;
      end
      if (m_axi_bready) begin
        m_axi_bvalid = !silent && b_c >= b_dly;
        m_axi_bresp = s_resp;
        b_c++;
      end else begin
        m_axi_bvalid = 0; b_c = 0;
      end
      if (m_axi_arvalid) begin
        seen_ar = 1;
        cap_araddr = m_axi_araddr;
        cap_arsize = m_axi_arsize;
        m_axi_arready = !silent && ar_c >= ar_dly;
        ar_c++;
      end else begin
        m_axi_arready = 0; ar_c = 0;
      end
      if (m_axi_rready) begin
        m_axi_rvalid = !silent && r_c >= r_dly;
        m_axi_rdata = s_rdata;
        m_axi_rresp = s_resp;
        m_axi_rlast = 1;
        r_c++;
      end else begin
        m_axi_rvalid = 0; r_c = 0;
      end
    end
  end

  bit split_seen, bad_bready;

  task automatic run_req(
    input bit rd, input bit wr, input bit fp,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] wdf, input logic [2:0] mode,
    input int budget,
    output int cyc, output int stalls, output bit to);
    @(negedge clk);
    seen_aw = 0; seen_ar = 0;
    split_seen = 0; bad_bready = 0;
    mem_read_m = rd; mem_write_m = wr; fp_store_m = fp;
    alu_rsl_m = addr; wdata_m = wd; wdata_f_m = wdf;
    mode_m = mode;
    cyc = 1; stalls = 0; to = 1;
    while (cyc <= budget) begin
      #1;
      if (done_m) begin
        to = 0;
        break;
      end
      if (stall_m) stalls++;
      if (!m_axi_awvalid && m_axi_wvalid) split_seen = 1;
      if (m_axi_bready && (m_axi_wvalid || m_axi_awvalid))
        bad_bready = 1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic end_req();
    @(negedge clk);
    mem_read_m = 0; mem_write_m = 0; fp_store_m = 0;
  endtask

  typedef struct {
    bit          rd, wr, fp;
    logic [31:0] addr, wd, wdf;
    logic [2:0]  mode;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          cyc;
    logic [31:0] load;
    bit          mis, berr, aw, ar;
    logic [31:0] xaddr, xwdata;
    logic [3:0]  xstrb;
    logic [2:0]  xsize;
  } vec_t;

  function automatic vec_t mkv(
    bit rd, bit wr, bit fp, logic [31:0] addr, logic [31:0] wd,
    logic [31:0] wdf, logic [2:0] mode, logic [31:0] rdata,
    logic [1:0] resp, int cyc, logic [31:0] load, bit mis,
    bit berr, bit aw, bit ar, logic [31:0] xaddr,
    logic [31:0] xwdata, logic [3:0] xstrb, logic [2:0] xsize);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fp = fp; v.addr = addr;
    v.wd = wd; v.wdf = wdf; v.mode = mode; v.rdata = rdata;
    v.resp = resp; v.cyc = cyc; v.load = load; v.mis = mis;
    v.berr = berr; v.aw = aw; v.ar = ar; v.xaddr = xaddr;
    v.xwdata = xwdata; v.xstrb = xstrb; v.xsize = xsize;
    return v;
  endfunction

  vec_t vt[13];

  initial begin
    int cyc, stalls;
    bit to, found;

    vt[0]  = mkv(1,0,0,32'h100,0,0,3'b010,32'hDEADBEEF,0,4,
                 32'hDEADBEEF,0,0,0,1,32'h100,0,0,3'd2);
    vt[1]  = mkv(1,0,0,32'h103,0,0,3'b000,32'h80FF0000,0,4,
                 32'hFFFFFF80,0,0,0,1,32'h103,0,0,3'd0);
    vt[2]  = mkv(1,0,0,32'h103,0,0,3'b100,32'h80FF0000,0,4,
                 32'h00000080,0,0,0,1,32'h103,0,0,3'd0);
    vt[3]  = mkv(1,0,0,32'h102,0,0,3'b101,32'h80FF0000,0,4,
                 32'h000080FF,0,0,0,1,32'h102,0,0,3'd1);
    vt[4]  = mkv(1,0,0,32'h102,0,0,3'b001,32'h80FF0000,0,4,
                 32'hFFFF80FF,0,0,0,1,32'h102,0,0,3'd1);
    vt[5]  = mkv(0,1,0,32'h201,32'hAB,0,3'b000,0,0,4,
                 0,0,0,1,0,32'h200,32'hABABABAB,4'b0010,3'd0);
    vt[6]  = mkv(0,1,0,32'h202,32'h1234,0,3'b001,0,0,4,
                 0,0,0,1,0,32'h200,32'h12341234,4'b1100,3'd1);
    vt[7]  = mkv(0,1,1,32'h204,32'h11111111,32'hCAFEF00D,
                 3'b010,0,0,4,0,0,0,1,0,32'h204,32'hCAFEF00D,
                 4'b1111,3'd2);
    vt[8]  = mkv(1,0,0,32'h102,0,0,3'b010,32'h55555555,0,2,
                 0,1,0,0,0,0,0,0,0);
    vt[9]  = mkv(0,1,0,32'h203,32'h1234,0,3'b001,0,0,2,
                 0,1,0,0,0,0,0,0,0);
    vt[10] = mkv(1,0,0,32'h108,0,0,3'b010,32'h12345678,2'b10,4,
                 32'h12345678,0,1,0,1,32'h108,0,0,3'd2);
    vt[11] = mkv(1,1,0,32'h20C,32'h0A0B0C0D,0,3'b010,0,0,4,
                 0,0,0,1,0,32'h20C,32'h0A0B0C0D,4'b1111,3'd2);
    vt[12] = mkv(1,0,0,32'h100,0,0,3'b001,32'h00007FFE,0,4,
                 32'h00007FFE,0,0,0,1,32'h100,0,0,3'd1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", done_m, 0);
    chk("rst_stall", stall_m, 0);
    chk("rst_load", load_data_m, 0);
    chk("rst_err", {misalign_err, bus_err}, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                       m_axi_arvalid, m_axi_rready}, 0);
    #1 rst = 0;

    foreach (vt[i]) begin
      s_rdata = vt[i].rdata;
      s_resp  = vt[i].resp;
      run_req(vt[i].rd, vt[i].wr, vt[i].fp, vt[i].addr,
              vt[i].wd, vt[i].wdf, vt[i].mode, 20,
              cyc, stalls, to);
      chk($sformatf("v%0d_to", i), to, 0);
      chk($sformatf("v%0d_cyc", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d_stall", i), stalls, vt[i].cyc - 1);
      chk($sformatf("v%0d_load", i), load_data_m, vt[i].load);
      chk($sformatf("v%0d_mis", i), misalign_err, vt[i].mis);
      chk($sformatf("v%0d_berr", i), bus_err, vt[i].berr);
      chk($sformatf("v%0d_stall_done", i), stall_m, 0);
      chk($sformatf("v%0d_seen_aw", i), seen_aw, vt[i].aw);
      chk($sformatf("v%0d_seen_ar", i), seen_ar, vt[i].ar);
      if (vt[i].aw) begin
        chk($sformatf("v%0d_awaddr", i), cap_awaddr, vt[i].xaddr);
        chk($sformatf("v%0d_wdata", i), cap_wdata, vt[i].xwdata);
        chk($sformatf("v%0d_wstrb", i), cap_wstrb, vt[i].xstrb);
        chk($sformatf("v%0d_awsize", i), cap_awsize, vt[i].xsize);
      end
      if (vt[i].ar) begin
        chk($sformatf("v%0d_araddr", i), cap_araddr, vt[i].xaddr);
        chk($sformatf("v%0d_arsize", i), cap_arsize, vt[i].xsize);
      end
      end_req();
    end

    // aw accepted 3 cycles before w
    s_resp = 0; aw_dly = 0; w_dly = 3;
    run_req(0, 1, 0, 32'h300, 32'h55AA55AA, 0, 3'b010, 20,
            cyc, stalls, to);
    chk("A_to", to, 0);
    chk("A_cyc", cyc, 7);
    chk("A_stall", stalls, 6);
    chk("A_split", split_seen, 1);
    chk("A_bready_early", bad_bready, 0);
    chk("A_wdata", cap_wdata, 32'h55AA55AA);
    chk("A_berr", bus_err, 0);
    end_req();
    w_dly = 0;

    // silent slave forces a timeout
    silent = 1;
    run_req(1, 0, 0, 32'h100, 0, 0, 3'b010, TO + 40,
            cyc, stalls, to);
    chk("B_to", to, 0);
    chk("B_cyc", cyc, TO + 2);
    chk("B_stall", stalls, TO + 1);
    chk("B_berr", bus_err, 1);
    chk("B_load", load_data_m, 0);
    chk("B_arvalid", m_axi_arvalid, 0);
    end_req();
    silent = 0;

    // reset while waiting for read data
    r_dly = 20; s_rdata = 32'hDEADBEEF; s_resp = 0;
    @(negedge clk);
    mem_read_m = 1; alu_rsl_m = 32'h100; mode_m = 3'b010;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (m_axi_rready) found = 1;
      else @(negedge clk);
    end
    chk("C_rready", found, 1);
    rst = 1;
    #1;
    chk("C_rready_clr", m_axi_rready, 0);
    chk("C_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                     m_axi_arvalid}, 0);
    chk("C_outs", {done_m, bus_err, misalign_err}, 0);
    chk("C_load", load_data_m, 0);
    mem_read_m = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    r_dly = 0;
    run_req(1, 0, 0, 32'h100, 0, 0, 3'b010, 20, cyc, stalls, to);
    chk("C_after_cyc", cyc, 4);
    chk("C_after_load", load_data_m, 32'hDEADBEEF);
    end_req();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
